// File: rtl/gpio_in_pattern_gen.sv
// Drives a programmable test pattern onto the FPGA-to-RPi GPIO lines.
// Each burst advances once per prescaled step and is framed by start/busy/done.
module gpio_in_pattern_gen #(
    parameter int GPIO_W   = 28,
    parameter int STEP_CNT = 50000000,
    parameter int NSTEP_W  = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [NSTEP_W-1:0] num_steps,
    output logic [GPIO_W-1:0]  gpio_out,
    output logic               busy,
    output logic               done,
    output logic               step_tick,
    output logic               led_1,
    output logic               led_2
);

    localparam int PW = (STEP_CNT > 2) ? $clog2(STEP_CNT) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(STEP_CNT - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t               state_r, state_s;
    logic [1:0]           mode_r, mode_s;
    logic [NSTEP_W-1:0]   nsteps_r, nsteps_s;
    logic [NSTEP_W-1:0]   step_cnt_r, step_cnt_s;
    logic [NSTEP_W-1:0]   step_inc_s;
    logic [PW-1:0]        presc_r, presc_s;
    logic [GPIO_W-1:0]    gpio_r, gpio_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
    logic                 tick_r, tick_s;
    logic                 led_r, led_s;

    function automatic logic [GPIO_W-1:0] seed_of(input logic [1:0] m);
        logic [GPIO_W-1:0] s;
        s = '0;
        case (m)
            2'd0: s = {{(GPIO_W-1){1'b0}}, 1'b1};
            2'd2: begin
                for (int i = 0; i < GPIO_W; i++) begin
                    s[i] = ((i % 2) == 0) ? 1'b1 : 1'b0;
                end
            end
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic logic [GPIO_W-1:0] advance(input logic [1:0] m,
                                                  input logic [GPIO_W-1:0] v);
        logic [GPIO_W-1:0] r;
        case (m)
            2'd0:    r = {v[GPIO_W-2:0], v[GPIO_W-1]};
            2'd1:    r = v + {{(GPIO_W-1){1'b0}}, 1'b1};
            default: r = ~v;
        endcase
        return r;
    endfunction

    assign step_inc_s = step_cnt_r + NSTEP_W'(1);

    // Next-state and next-output logic for the IDLE/RUN burst controller.
    always_comb begin
        state_s    = state_r;
        mode_s     = mode_r;
        nsteps_s   = nsteps_r;
        step_cnt_s = step_cnt_r;
        presc_s    = presc_r;
        gpio_s     = gpio_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        tick_s     = 1'b0;
        led_s      = led_r;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                if (start) begin
                    state_s    = RUN;
                    mode_s     = mode;
                    nsteps_s   = num_steps;
                    step_cnt_s = '0;
                    presc_s    = '0;
                    gpio_s     = seed_of(mode);
                    busy_s     = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                // stop wins over a coinciding tick: no advance, no done
                if (stop) begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                    presc_s = '0;
                end else if (presc_r == PRESC_MAX) begin
                    presc_s    = '0;
                    gpio_s     = advance(mode_r, gpio_r);
                    tick_s     = 1'b1;
                    led_s      = ~led_r;
                    step_cnt_s = step_inc_s;
                    if ((nsteps_r != '0) && (step_inc_s == nsteps_r)) begin
                        done_s  = 1'b1;
                        state_s = IDLE;
                        busy_s  = 1'b0;
                    end else begin
                        busy_s = 1'b1;
                    end
                end else begin
                    presc_s = presc_r + PW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r    <= IDLE;
            mode_r     <= 2'd0;
            nsteps_r   <= '0;
            step_cnt_r <= '0;
            presc_r    <= '0;
            gpio_r     <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            tick_r     <= 1'b0;
            led_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            mode_r     <= mode_s;
            nsteps_r   <= nsteps_s;
            step_cnt_r <= step_cnt_s;
            presc_r    <= presc_s;
            gpio_r     <= gpio_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            tick_r     <= tick_s;
            led_r      <= led_s;
        end
    end

    assign gpio_out  = gpio_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign step_tick = tick_r;
    assign led_1     = busy_r;
    assign led_2     = led_r;

endmodule

// File: tb/tb_gpio_in_pattern_gen.sv
// Directed bench for gpio_in_pattern_gen with a short step period (STEP_CNT=4).
module tb_gpio_in_pattern_gen;

    localparam int GPIO_W   = 28;
    localparam int STEP_CNT = 4;
    localparam int NSTEP_W  = 16;

    logic               sys_clk = 1'b0;
    logic               sys_rst;
    logic               start;
    logic               stop;
    logic [1:0]         mode;
    logic [NSTEP_W-1:0] num_steps;
    logic [GPIO_W-1:0]  gpio_out;
    logic               busy;
    logic               done;
    logic               step_tick;
    logic               led_1;
    logic               led_2;

    int   n_checks = 0;
    int   n_errors = 0;
    logic led_exp  = 1'b0;

    gpio_in_pattern_gen #(
        .GPIO_W(GPIO_W), .STEP_CNT(STEP_CNT), .NSTEP_W(NSTEP_W)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .stop(stop),
        .mode(mode), .num_steps(num_steps), .gpio_out(gpio_out), .busy(busy),
        .done(done), .step_tick(step_tick), .led_1(led_1), .led_2(led_2)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [1:0]         mode;
        logic [NSTEP_W-1:0] n;
        logic [GPIO_W-1:0]  seed;
        logic [GPIO_W-1:0]  fin;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [GPIO_W-1:0] adv(input logic [1:0] m, input logic [GPIO_W-1:0] v);
        case (m)
            2'd0:    return {v[GPIO_W-2:0], v[GPIO_W-1]};
            2'd1:    return v + 28'd1;
            default: return ~v;
        endcase
    endfunction

    // Start one burst and follow it cycle by cycle until done (bounded).
    task automatic run_burst(input vec_t v, input bit inject);
        int               cyc;
        int               ticks;
        int               last_tick;
        bit               got_done;
        logic [GPIO_W-1:0] exp_pat;
        logic [GPIO_W-1:0] prev;
        @(negedge sys_clk);
        start = 1'b1; mode = v.mode; num_steps = v.n;
        @(negedge sys_clk);
        start = 1'b0;
        chk("seed", 32'(gpio_out), 32'(v.seed));
        chk("busy_on", 32'(busy), 32'd1);
        exp_pat = v.seed; prev = gpio_out;
        cyc = 0; ticks = 0; last_tick = 0; got_done = 1'b0;
        while (!got_done && cyc < int'(v.n) * STEP_CNT + 40) begin
            @(negedge sys_clk);
            cyc++;
            chk("led1_eq_busy", 32'(led_1), 32'(busy));
            if (step_tick) begin
                ticks++;
                exp_pat = adv(v.mode, exp_pat);
                chk("step_val", 32'(gpio_out), 32'(exp_pat));
                if (ticks == 1) chk("first_tick", 32'(cyc), 32'd4);
                else            chk("tick_period", 32'(cyc - last_tick), 32'd4);
                last_tick = cyc;
            end else begin
                chk("hold_between_ticks", 32'(gpio_out), 32'(prev));
            end
            if (done) begin
                got_done = 1'b1;
                chk("done_with_tick", 32'(step_tick), 32'd1);
            end
            prev = gpio_out;
            if (inject && cyc == 2) begin
                start = 1'b1; mode = v.mode ^ 2'd1; num_steps = 16'd7;
            end else if (cyc == 3) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(got_done), 32'd1);
        chk("final_val", 32'(gpio_out), 32'(v.fin));
        chk("tick_count", 32'(ticks), 32'(v.n));
        @(negedge sys_clk);
        chk("busy_off", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("tick_one_cycle", 32'(step_tick), 32'd0);
        led_exp = led_exp ^ v.n[0];
        chk("led2_toggles", 32'(led_2), 32'(led_exp));
    endtask

    initial begin
        int ticks;
        int guard;
        logic [GPIO_W-1:0] held;

        vecs[0] = '{2'd0, 16'd30, 28'h0000001, 28'h0000004};
        vecs[1] = '{2'd2, 16'd3,  28'h5555555, 28'hAAAAAAA};
        vecs[2] = '{2'd1, 16'd5,  28'h0000000, 28'h0000005};
        vecs[3] = '{2'd3, 16'd1,  28'h0000000, 28'hFFFFFFF};
        vecs[4] = '{2'd3, 16'd2,  28'h0000000, 28'h0000000};
        vecs[5] = '{2'd0, 16'd28, 28'h0000001, 28'h0000001};
        vecs[6] = '{2'd1, 16'd1,  28'h0000000, 28'h0000001};

        sys_rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; num_steps = '0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("rst_gpio", 32'(gpio_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tick", 32'(step_tick), 32'd0);
        chk("rst_led1", 32'(led_1), 32'd0);
        chk("rst_led2", 32'(led_2), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_burst(vecs[i], (i % 2) == 0);
        end

        // stop while idle must leave everything untouched
        held = gpio_out;
        @(negedge sys_clk); stop = 1'b1;
        @(negedge sys_clk); stop = 1'b0;
        @(negedge sys_clk);
        chk("idle_stop_gpio", 32'(gpio_out), 32'(held));
        chk("idle_stop_busy", 32'(busy), 32'd0);
        chk("idle_stop_tick", 32'(step_tick), 32'd0);

        // continuous count, stop lands exactly on the sixth tick edge
        @(negedge sys_clk); start = 1'b1; mode = 2'd1; num_steps = 16'd0;
        @(negedge sys_clk); start = 1'b0;
        ticks = 0; guard = 0;
        while (ticks < 5 && guard < 60) begin
            @(negedge sys_clk);
            guard++;
            if (step_tick) ticks++;
        end
        chk("cont_ticks", 32'(ticks), 32'd5);
        chk("cont_val", 32'(gpio_out), 32'h0000005);
        chk("cont_no_done", 32'(done), 32'd0);
        repeat (3) @(negedge sys_clk);
        stop = 1'b1;
        @(negedge sys_clk);
        stop = 1'b0;
        chk("stop_gpio_hold", 32'(gpio_out), 32'h0000005);
        chk("stop_no_tick", 32'(step_tick), 32'd0);
        chk("stop_no_done", 32'(done), 32'd0);
        chk("stop_busy_off", 32'(busy), 32'd0);
        led_exp = ~led_exp;
        chk("stop_led2", 32'(led_2), 32'(led_exp));
        repeat (6) @(negedge sys_clk);
        chk("stop_stays_idle", 32'(gpio_out), 32'h0000005);

        // reset in the middle of an all-toggle run
        @(negedge sys_clk); start = 1'b1; mode = 2'd3; num_steps = 16'd0;
        @(negedge sys_clk); start = 1'b0;
        ticks = 0; guard = 0;
        while (ticks < 3 && guard < 60) begin
            @(negedge sys_clk);
            guard++;
            if (step_tick) ticks++;
        end
        chk("toggle_pre_rst", 32'(gpio_out), 32'h0FFFFFFF);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("midrst_gpio", 32'(gpio_out), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_led1", 32'(led_1), 32'd0);
        chk("midrst_led2", 32'(led_2), 32'd0);
        chk("midrst_tick", 32'(step_tick), 32'd0);
        led_exp = 1'b0;
        repeat (6) @(negedge sys_clk);
        chk("midrst_idle", 32'(busy), 32'd0);
        run_burst('{2'd3, 16'd2, 28'h0000000, 28'h0000000}, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gpio_in_pattern_gen.md
Name: gpio_in_pattern_gen

Overview:
- Drives a programmable test pattern onto the 28 FPGA-to-RPi GPIO lines (RPi_GPIO_IN) so RPi software can verify its input path.
- Pairs with the RPi-output capture path, which covers the opposite direction.
- Patterns advance once per prescaled step period.
- A start/busy/done handshake frames each burst of steps.
- Two LEDs show run status and a step heartbeat.

Parameters:
- GPIO_W, 28, width of the pattern bus.
- STEP_CNT, 50000000, sys_clk cycles per pattern step (≥2).
- NSTEP_W, 16, width of the step-count input.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- stop  in  1  abort request; sampled only in RUN.
- mode  in  2  pattern select, latched at start: 0 walking-one, 1 binary count, 2 alternating 0x5555555/0xAAAAAAA, 3 all-toggle.
- num_steps  in  NSTEP_W  number of advances per burst, latched at start; 0 = continuous until stop.
- gpio_out  out  GPIO_W  pattern to the RPi GPIO pins.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on natural completion of a burst.
- step_tick  out  1  one-cycle pulse on the cycle gpio_out advances.
- led_1  out  1  equals busy.
- led_2  out  1  heartbeat; toggles on every step_tick.

Behaviour:
- Reset (synchronous, sys_rst=1 at a sys_clk edge):
  - State=IDLE.
  - gpio_out, busy, done, step_tick, led_2, prescaler and step counter all 0.
  - Reset mid-RUN aborts immediately with the same values.
- FSM: IDLE, RUN.
- IDLE→RUN when start=1:
  - Latches mode and num_steps.
  - Clears the prescaler and step counter.
  - Loads the seed into gpio_out on the same edge.
  - busy=1 from the next cycle.
  - Seeds: mode0 0x0000001, mode1 0x0000000, mode2 0x5555555, mode3 0x0000000.
- In RUN, the prescaler counts 0..STEP_CNT-1. Reaching STEP_CNT-1 is a tick; the prescaler wraps to 0 and the following happen on that edge:
  - gpio_out advances.
  - step_tick pulses.
  - led_2 toggles.
  - The step counter increments.
- First advance occurs exactly STEP_CNT cycles after the seed appears.
- Advance rules:
  - mode0: rotate left 1; bit27 wraps to bit0.
  - mode1: +1 modulo 2^28; 0xFFFFFFF wraps to 0.
  - mode2: bitwise invert.
  - mode3: bitwise invert (0x0000000 ↔ 0xFFFFFFF).
- Completion: when a tick makes the step counter equal num_steps (num_steps≠0):
  - That edge applies the final advance and pulses done.
  - It returns to IDLE, and busy=0 from the next cycle.
- num_steps=0: never completes; the step counter wraps silently.
- stop in RUN:
  - Returns to IDLE on that edge.
  - No advance and no step_tick that cycle, even if a tick coincides.
  - done is not pulsed.
- start while in RUN is ignored. stop while in IDLE is ignored.
- gpio_out holds its last value in IDLE until the next start or reset.
- led_2 holds its value in IDLE.
- done and step_tick are never high for more than one cycle.
- mode/num_steps changes during RUN have no effect.

Test Plan (STEP_CNT=4):
- Reset, then walking-one: start, mode=0, num_steps=30.
  - gpio_out=0x0000001 after the start edge.
  - Then 0x0000002 four cycles later.
  - After 28 steps gpio_out=0x0000001 (wrap).
  - Step 30 gives 0x0000004 with done=1 for one cycle; busy drops the next cycle.
- Counter wrap: start, mode=1, num_steps=0; force the step counter irrelevant.
  - Run 5 steps: gpio_out=0x0000005.
  - Assert stop on a tick cycle: gpio_out stays 0x0000005, no step_tick, no done, busy=0 next cycle.
- Alternating: start, mode=2, num_steps=3.
  - gpio_out 0x5555555 → 0xAAAAAAA → 0x5555555 → 0xAAAAAAA.
  - done coincides with the third step_tick.
  - led_2 toggles 3 times.
- Handshake robustness:
  - start pulses during RUN are ignored, and the burst length is unchanged.
  - stop in IDLE has no effect.
  - mode changes mid-run have no effect on the sequence.
- Reset mid-run: mode=3 at step 2, assert sys_rst for 1 cycle.
  - All outputs 0 on the next cycle, state IDLE.
  - A subsequent start restarts from seed 0x0000000.
- Timing: measure cycles between consecutive step_tick pulses = 4.
  - led_1 equals busy throughout.
  - gpio_out changes only on step_tick or start edges.
